branch_unit: RTL and testbench

//  Program-counter sequencer; the consumer side of the condition comparator.

---
 rtl/branch_unit_pkg.sv | 32 +++
 rtl/branch_unit_if.sv | 32 +++
 rtl/bu_target_add.sv | 21 ++
 rtl/branch_unit.sv | 120 ++++++++++++
 tb/tb_branch_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit: comparator condition codes and
// the sequencer FSM state encoding.
package branch_unit_pkg;

  // Condition codes, matching the comparator's decode table.
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_RESOLVE  = 2'd1,
    ST_REDIRECT = 2'd2
  } bu_state_e;

endpackage

// File: rtl/branch_unit_if.sv
// Decode / comparator / fetch-side signal bundle of the branch unit.
// master = decode and comparator side, slave = branch_unit.
interface branch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 16
);
  logic              run;
  logic              instr_valid;
  logic              is_cmp;
  logic              is_branch;
  logic              is_link;
  logic [3:0]        cond_in;
  logic [OFF_W-1:0]  offset;
  logic              F;
  logic [ADDR_W-1:0] pc;
  logic              cmp_e;
  logic [3:0]        cond;
  logic              stall;
  logic              flush;
  logic              taken;
  logic [ADDR_W-1:0] lr;

  modport master (
    output run, instr_valid, is_cmp, is_branch, is_link, cond_in, offset, F,
    input  pc, cmp_e, cond, stall, flush, taken, lr
  );

  modport slave (
    input  run, instr_valid, is_cmp, is_branch, is_link, cond_in, offset, F,
    output pc, cmp_e, cond, stall, flush, taken, lr
  );
endinterface

// File: rtl/bu_target_add.sv
// Sign-extends a two's complement displacement to the address width and adds
// it to a base address, wrapping modulo 2^ADDR_W.
module bu_target_add #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [OFF_W-1:0]  off,
  output logic [ADDR_W-1:0] sum
);
  logic [ADDR_W-1:0] off_ext;

  if (OFF_W >= ADDR_W) begin : g_trunc
    assign off_ext = off[ADDR_W-1:0];
  end else begin : g_sext
    assign off_ext = {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  end

  // Carry out of the top bit is dropped: address arithmetic wraps.
  assign sum = base + off_ext;
endmodule

// File: rtl/branch_unit.sv
// Program-counter sequencer: advances the PC, enables the comparator on CMP,
// resolves conditional branches against the comparator's F result, redirects
// fetch on taken branches and optionally writes the link register.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                OFF_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_unit_if.slave     bus
);
  bu_state_e         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] lr_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [ADDR_W-1:0] bpc_q;
  logic [3:0]        cond_q;
  logic              link_q;
  logic              taken_q;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] bpc_inc;
  logic [ADDR_W-1:0] tgt_sum;
  logic              accept;
  logic              cmp_e;

  // Branch target, sequential PC and return address all share one adder shape.
  bu_target_add #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) u_tgt_add (
    .base (pc_q),
    .off  (bus.offset),
    .sum  (tgt_sum)
  );

  bu_target_add #(.ADDR_W(ADDR_W), .OFF_W(2)) u_pc_inc (
    .base (pc_q),
    .off  (2'b01),
    .sum  (pc_inc)
  );

  bu_target_add #(.ADDR_W(ADDR_W), .OFF_W(2)) u_bpc_inc (
    .base (bpc_q),
    .off  (2'b01),
    .sum  (bpc_inc)
  );

  // An instruction is consumed only in FETCH with fetch advancing.
  assign accept = (state_q == ST_FETCH) && bus.run && bus.instr_valid;

  // Comparator enable: same-cycle, suppressed when the instruction is a branch.
  always_comb begin
    // NOTE: default first so every path assigns cmp_e and no latch is inferred.
    cmp_e = 1'b0;
    if (accept && bus.is_cmp && !bus.is_branch) begin
      cmp_e = 1'b1;
    end
  end

  // Sequencer FSM with its PC, condition, link and branch-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      cond_q  <= COND_NV;
      lr_q    <= '0;
      tgt_q   <= '0;
      bpc_q   <= '0;
      link_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      taken_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            if (bus.is_branch) begin
              cond_q  <= bus.cond_in;
              tgt_q   <= tgt_sum;
              bpc_q   <= pc_q;
              link_q  <= bus.is_link;
              state_q <= ST_RESOLVE;
            end else begin
              pc_q <= pc_inc;
            end
          end
        end
        ST_RESOLVE: begin
          cond_q <= COND_NV;
          if (bus.F) begin
            pc_q    <= tgt_q;
            taken_q <= 1'b1;
            if (link_q) begin
              lr_q <= bpc_inc;
            end
            state_q <= ST_REDIRECT;
          end else begin
            pc_q    <= bpc_inc;
            state_q <= ST_FETCH;
          end
        end
        ST_REDIRECT: begin
          state_q <= ST_FETCH;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.pc    = pc_q;
  assign bus.lr    = lr_q;
  assign bus.cond  = cond_q;
  assign bus.taken = taken_q;
  assign bus.cmp_e = cmp_e;
  assign bus.stall = (state_q != ST_FETCH);
  assign bus.flush = (state_q == ST_REDIRECT);
endmodule

// File: tb/tb_branch_unit.sv
// Directed testbench for branch_unit: a cycle-by-cycle vector table plus
// hand-written sequences for reset, latency, wrap-around and link cases.
module tb_branch_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  branch_unit_if #(.ADDR_W(16), .OFF_W(16)) bu_if ();

  branch_unit #(.ADDR_W(16), .OFF_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        run, iv, cmp, br, lnk;
    logic [3:0]  cin;
    logic [15:0] off;
    logic        f;
    logic        e_cmp_e;
    logic [15:0] e_pc;
    logic [3:0]  e_cond;
    logic        e_stall, e_flush, e_taken;
    logic [15:0] e_lr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic c, input logic b,
                       input logic l, input logic [3:0] ci, input logic [15:0] o);
    bu_if.run         = r;
    bu_if.instr_valid = v;
    bu_if.is_cmp      = c;
    bu_if.is_branch   = b;
    bu_if.is_link     = l;
    bu_if.cond_in     = ci;
    bu_if.offset      = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    bu_if.F = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic seq_instr(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
  endtask

  // Accept a branch, resolve it with F=fv (run=rr during RESOLVE), and if taken
  // step through REDIRECT.
  task automatic do_branch(input string nm, input logic [3:0] c, input logic [15:0] off,
                           input logic lnk, input logic fv, input logic rr,
                           input logic [15:0] e_pc, input logic [15:0] e_lr);
    drive(1'b1, 1'b1, 1'b0, 1'b1, lnk, c, off);
    bu_if.F = 1'b0;
    tick();
    check({nm, "_acc_stall"}, 32'(bu_if.stall), 32'd1);
    check({nm, "_acc_cond"}, 32'(bu_if.cond), 32'(c));
    drive(rr, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    bu_if.F = fv;
    tick();
    check({nm, "_pc"}, 32'(bu_if.pc), 32'(e_pc));
    check({nm, "_lr"}, 32'(bu_if.lr), 32'(e_lr));
    check({nm, "_taken"}, 32'(bu_if.taken), 32'(fv));
    check({nm, "_flush"}, 32'(bu_if.flush), 32'(fv));
    bu_if.F = 1'b0;
    if (fv) begin
      tick();
      check({nm, "_redir_done"}, 32'(bu_if.stall), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            run   iv    cmp   br    lnk   cin   off      f     cmp_e pc       cond  st    fl    tk    lr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0001, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 16'h0002, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0003, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0004, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0005, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0005, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0005, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0008, 1'b0, 1'b0, 16'h0005, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0008, 1'b0, 1'b0, 16'h0006, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 16'h0008, 1'b0, 1'b0, 16'h0006, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 16'h000E, 4'hF, 1'b1, 1'b1, 1'b1, 16'h0007};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h000E, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0007};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h000F, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0007};

    // Reset state.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    bu_if.F = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", 32'(bu_if.pc), 32'h0);
    check("rst_cond", 32'(bu_if.cond), 32'hF);
    check("rst_lr", 32'(bu_if.lr), 32'h0);
    check("rst_taken", 32'(bu_if.taken), 32'h0);
    check("rst_stall", 32'(bu_if.stall), 32'h0);
    check("rst_flush", 32'(bu_if.flush), 32'h0);
    rst_n = 1'b1;

    // Table-driven cycle sequence.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].run, vecs[i].iv, vecs[i].cmp, vecs[i].br, vecs[i].lnk, vecs[i].cin, vecs[i].off);
      bu_if.F = vecs[i].f;
      #1;
      check($sformatf("vec%0d_cmp_e", i), 32'(bu_if.cmp_e), 32'(vecs[i].e_cmp_e));
      tick();
      check($sformatf("vec%0d_pc", i), 32'(bu_if.pc), 32'(vecs[i].e_pc));
      check($sformatf("vec%0d_cond", i), 32'(bu_if.cond), 32'(vecs[i].e_cond));
      check($sformatf("vec%0d_stall", i), 32'(bu_if.stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_flush", i), 32'(bu_if.flush), 32'(vecs[i].e_flush));
      check($sformatf("vec%0d_taken", i), 32'(bu_if.taken), 32'(vecs[i].e_taken));
      check($sformatf("vec%0d_lr", i), 32'(bu_if.lr), 32'(vecs[i].e_lr));
    end

    // Taken BEQ at pc=4, offset +8: redirect to 0x000C, next accept 3 cycles on.
    do_reset();
    seq_instr(4);
    check("beq_start_pc", 32'(bu_if.pc), 32'h0004);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0008);
    tick();
    check("beq_e0_flush", 32'(bu_if.flush), 32'h0);
    check("beq_e0_cond", 32'(bu_if.cond), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    bu_if.F = 1'b1;
    tick();
    bu_if.F = 1'b0;
    check("beq_e1_pc", 32'(bu_if.pc), 32'h000C);
    check("beq_e1_taken", 32'(bu_if.taken), 32'h1);
    check("beq_e1_flush", 32'(bu_if.flush), 32'h1);
    check("beq_e1_cond", 32'(bu_if.cond), 32'hF);
    tick();
    check("beq_e2_taken", 32'(bu_if.taken), 32'h0);
    check("beq_e2_flush", 32'(bu_if.flush), 32'h0);
    check("beq_e2_pc", 32'(bu_if.pc), 32'h000C);
    tick();
    check("beq_e3_pc", 32'(bu_if.pc), 32'h000D);

    // Same branch not taken: pc=5 after 2 cycles, no flush or taken.
    do_reset();
    seq_instr(4);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0008);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    bu_if.F = 1'b0;
    check("bnt_e0_taken", 32'(bu_if.taken), 32'h0);
    tick();
    check("bnt_e1_pc", 32'(bu_if.pc), 32'h0005);
    check("bnt_e1_taken", 32'(bu_if.taken), 32'h0);
    check("bnt_e1_flush", 32'(bu_if.flush), 32'h0);
    check("bnt_e1_cond", 32'(bu_if.cond), 32'hF);
    check("bnt_e1_stall", 32'(bu_if.stall), 32'h0);
    tick();
    check("bnt_e2_pc", 32'(bu_if.pc), 32'h0006);

    // Wrap: backward branch from 0x0002 by -4, then sequential through 0xFFFF.
    do_reset();
    seq_instr(2);
    do_branch("wrap_br", 4'h0, 16'hFFFC, 1'b0, 1'b1, 1'b1, 16'hFFFE, 16'h0000);
    seq_instr(1);
    check("wrap_seq1", 32'(bu_if.pc), 32'hFFFF);
    seq_instr(1);
    check("wrap_seq2", 32'(bu_if.pc), 32'h0000);

    // BL at 0x0010 resolved with run=0: lr=0x0011; plain branch leaves lr alone.
    do_reset();
    do_branch("b_to_10", 4'hE, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
    do_branch("bl", 4'h0, 16'h0004, 1'b1, 1'b1, 1'b0, 16'h0014, 16'h0011);
    do_branch("bl_nt", 4'h1, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0015, 16'h0011);

    // Asynchronous reset in RESOLVE discards the in-flight branch.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 16'h0004);
    tick();
    check("arst_pre_stall", 32'(bu_if.stall), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(bu_if.pc), 32'h0);
    check("arst_cond", 32'(bu_if.cond), 32'hF);
    check("arst_stall", 32'(bu_if.stall), 32'h0);
    check("arst_flush", 32'(bu_if.flush), 32'h0);
    check("arst_lr", 32'(bu_if.lr), 32'h0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    bu_if.F = 1'b1;
    tick();
    bu_if.F = 1'b0;
    check("arst_post_pc", 32'(bu_if.pc), 32'h0);
    check("arst_post_taken", 32'(bu_if.taken), 32'h0);
    check("arst_post_lr", 32'(bu_if.lr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
